// File: rtl/cu_pkg.sv
// Shared opcodes, FSM state encoding and instruction field positions for the
// single-bus datapath control unit.
package cu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int IR_OPC_HI = 31;
    localparam int IR_OPC_LO = 27;
    localparam int IR_RA_HI  = 26;
    localparam int IR_RA_LO  = 23;
    localparam int IR_RB_HI  = 22;
    localparam int IR_RB_LO  = 19;
    localparam int IR_RC_HI  = 18;
    localparam int IR_RC_LO  = 15;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        T0     = 4'd1,
        T1     = 4'd2,
        T2     = 4'd3,
        T3     = 4'd4,
        T4     = 4'd5,
        T5     = 4'd6,
        T6     = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef struct packed {
        logic alu;
        logic muldiv;
        logic nop;
        logic halt;
        logic illegal;
    } op_class_t;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[IR_OPC_HI:IR_OPC_LO];
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode classifier: sorts an opcode into exactly one of
// alu / muldiv / nop / halt / illegal.
module cu_decode
    import cu_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class.alu     = 1'b1;
            OP_MUL, OP_DIV:                 op_class.muldiv  = 1'b1;
            OP_NOP:                         op_class.nop     = 1'b1;
            OP_HALT:                        op_class.halt    = 1'b1;
            default:                        op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/datapath_control_unit.sv
// Moore sequencer driving the single-bus datapath strobes through T0-T6.
// Optional memory wait states in T1 are enabled with `define CU_WAIT_STATE_EN.
module datapath_control_unit
    import cu_pkg::*;
(
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    input  logic        stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIout,
    output logic        LOout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_op,
    output logic        run
);

    state_t    state;
    state_t    next_state;
    op_class_t op_class;
    logic [4:0] opcode;
    logic      first_t1;
    logic      unused_bits;

    assign opcode      = ir_opcode(ir);
    assign unused_bits = ^{ir[IR_RA_HI:0], mem_ready};

    cu_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    always_ff @(posedge Clock) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (clear)
            state <= S_IDLE;
        else
            state <= next_state;
    end

`ifdef CU_WAIT_STATE_EN
    // Marks repeat T1 cycles so the PC update strobes fire only on the first one.
    logic t1_hold;

    always_ff @(posedge Clock) begin
        if (clear)
            t1_hold <= 1'b0;
        else
            t1_hold <= (state == T1) && !mem_ready;
    end

    assign first_t1 = !t1_hold;
`else
    assign first_t1 = 1'b1;
`endif

    always_comb begin
        // NOTE: default first; every path then assigns next_state, so no latch is inferred.
        next_state = state;
        case (state)
            S_IDLE: next_state = T0;
            T0:     next_state = T1;
`ifdef CU_WAIT_STATE_EN
            T1:     next_state = mem_ready ? T2 : T1;
`else
            T1:     next_state = T2;
`endif
            T2:     next_state = T3;
            T3: begin
                if (op_class.alu || op_class.muldiv)
                    next_state = T4;
                else if (op_class.halt || stop)
                    next_state = S_HALT;
                else
                    next_state = T0;
            end
            T4:     next_state = T5;
            T5: begin
                if (op_class.muldiv)
                    next_state = T6;
                else
                    next_state = stop ? S_HALT : T0;
            end
            T6:     next_state = stop ? S_HALT : T0;
            S_HALT: next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = OP_NOP;
        run      = (state != S_IDLE) && (state != S_HALT);
        case (state)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (first_t1) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (op_class.alu || op_class.muldiv) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end
            end
            T4: begin
                Grc    = 1'b1;
                Rout   = 1'b1;
                Zin    = 1'b1;
                alu_op = opcode;
            end
            T5: begin
                if (op_class.alu) begin
                    Zlowout = 1'b1;
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                end else if (op_class.muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_control_unit.sv
// Self-checking bench: a small single-bus datapath driven by the unit, an
// expected per-cycle strobe trace built from each instruction, and a register model.
module tb_datapath_control_unit;
    import cu_pkg::*;

    logic        Clock;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;
    logic PCout, Zlowout, Zhighout, HIout, LOout, MDRout;
    logic MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout;
    logic [4:0] alu_op;
    logic       run;

    datapath_control_unit dut (
        .Clock(Clock), .clear(clear), .ir(ir), .mem_ready(mem_ready), .stop(stop),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIout(HIout),
        .LOout(LOout), .MDRout(MDRout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
        .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .alu_op(alu_op), .run(run)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [20:0] M_PCOUT    = 21'd1 << 20;
    localparam logic [20:0] M_ZLOWOUT  = 21'd1 << 19;
    localparam logic [20:0] M_ZHIGHOUT = 21'd1 << 18;
    localparam logic [20:0] M_MDROUT   = 21'd1 << 15;
    localparam logic [20:0] M_MARIN    = 21'd1 << 14;
    localparam logic [20:0] M_PCIN     = 21'd1 << 13;
    localparam logic [20:0] M_MDRIN    = 21'd1 << 12;
    localparam logic [20:0] M_IRIN     = 21'd1 << 11;
    localparam logic [20:0] M_YIN      = 21'd1 << 10;
    localparam logic [20:0] M_ZIN      = 21'd1 << 9;
    localparam logic [20:0] M_HIIN     = 21'd1 << 8;
    localparam logic [20:0] M_LOIN     = 21'd1 << 7;
    localparam logic [20:0] M_INCPC    = 21'd1 << 6;
    localparam logic [20:0] M_READ     = 21'd1 << 5;
    localparam logic [20:0] M_GRA      = 21'd1 << 4;
    localparam logic [20:0] M_GRB      = 21'd1 << 3;
    localparam logic [20:0] M_GRC      = 21'd1 << 2;
    localparam logic [20:0] M_RIN      = 21'd1 << 1;
    localparam logic [20:0] M_ROUT     = 21'd1 << 0;

    logic [20:0] dut_strb;
    assign dut_strb = {PCout, Zlowout, Zhighout, HIout, LOout, MDRout, MARin, PCin,
                       MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read, Gra, Grb,
                       Grc, Rin, Rout};

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        case (op)
            OP_ADD:  return {32'h0, a + b};
            OP_SUB:  return {32'h0, a - b};
            OP_AND:  return {32'h0, a & b};
            OP_OR:   return {32'h0, a | b};
            OP_SHR:  return {32'h0, a >> s};
            OP_SHL:  return {32'h0, a << s};
            OP_ROR:  return {32'h0, (a >> s) | (a << (32 - s))};
            OP_ROL:  return {32'h0, (a << s) | (a >> (32 - s))};
            OP_MUL:  return {32'h0, a} * {32'h0, b};
            OP_DIV:  return (b == 32'h0) ? 64'h0 : {a % b, a / b};
            default: return 64'h0;
        endcase
    endfunction

    // Datapath harness: memory, PC/MAR/MDR/IR/Y/Z/HI/LO and a 16-entry register file.
    logic [31:0] mem [0:63];
    logic [31:0] regs [0:15];
    logic [31:0] init_regs [0:15];
    logic [31:0] pc, mar, mdr, ir_r, y, hi, lo, bus;
    logic [63:0] z;
    logic [3:0]  rsel;
    logic        dp_load;

    assign ir = ir_r;

    always_comb begin
        rsel = ir_r[IR_RC_HI:IR_RC_LO];
        if (Grb) rsel = ir_r[IR_RB_HI:IR_RB_LO];
        if (Gra) rsel = ir_r[IR_RA_HI:IR_RA_LO];
    end

    always_comb begin
        bus = 32'h0;
        if (PCout)    bus = pc;
        if (Zlowout)  bus = z[31:0];
        if (Zhighout) bus = z[63:32];
        if (HIout)    bus = hi;
        if (LOout)    bus = lo;
        if (MDRout)   bus = mdr;
        if (Rout)     bus = regs[rsel];
    end

    always @(posedge Clock) begin
        if (dp_load) begin
            pc <= 32'h0; mar <= 32'h0; mdr <= 32'h0; ir_r <= 32'h0;
            y <= 32'h0; z <= 64'h0; hi <= 32'h0; lo <= 32'h0;
            for (int i = 0; i < 16; i++) regs[i] <= init_regs[i];
        end else begin
            if (MARin) mar <= bus;
            if (PCin)  pc <= bus;
            if (MDRin) mdr <= Read ? mem[mar[5:0]] : bus;
            if (IRin)  ir_r <= bus;
            if (Yin)   y <= bus;
            if (Zin)   z <= IncPC ? {32'h0, bus + 32'd1} : alu_model(alu_op, y, bus);
            if (HIin)  hi <= bus;
            if (LOin)  lo <= bus;
            if (Rin)   regs[rsel] <= bus;
        end
    end

    // Expected trace: one entry per cycle with the inputs to drive and outputs to see.
    typedef struct packed {
        logic [20:0] strb;
        logic [4:0]  op;
        logic        rn;
        logic        mrdy;
        logic        stp;
        logic        clr;
    } exp_t;

    exp_t q[$];
    logic [31:0] ref_regs [0:15];
    logic [31:0] ref_hi, ref_lo;
    int          ref_pc = 0;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic ready_last();
`ifdef CU_WAIT_STATE_EN
        return 1'b1;
`else
        return rbit();
`endif
    endfunction

    task automatic push(input logic [20:0] strb, input logic [4:0] op, input logic rn,
                        input logic mrdy, input logic stp, input logic clr);
        exp_t e;
        e.strb = strb; e.op = op; e.rn = rn; e.mrdy = mrdy; e.stp = stp; e.clr = clr;
        q.push_back(e);
    endtask

    task automatic push_idle();
        push(21'h0, OP_NOP, 1'b0, rbit(), 1'b0, 1'b0);
    endtask

    task automatic push_halt(input int n, input logic clr_end);
        for (int i = 0; i < n; i++)
            push(21'h0, OP_NOP, 1'b0, rbit(), rbit(), clr_end && (i == n - 1));
        if (clr_end) push_idle();
    endtask

    task automatic add_instr(input logic [4:0] opc, input int ra, input int rb, input int rc,
                             input int waits, input logic stp, input logic abort);
        logic [63:0] res;
        bit is_alu, is_md;
        is_alu = opc inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};
        is_md  = opc inside {OP_MUL, OP_DIV};
        mem[ref_pc] = {opc, 4'(ra), 4'(rb), 4'(rc), 15'h0};
        ref_pc++;
`ifndef CU_WAIT_STATE_EN
        waits = 0;
`endif
        push(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, OP_NOP, 1'b1, rbit(), stp, 1'b0);
        if (waits == 0) begin
            push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, OP_NOP, 1'b1, ready_last(), stp, 1'b0);
        end else begin
            push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, OP_NOP, 1'b1, 1'b0, stp, 1'b0);
            for (int i = 1; i < waits; i++)
                push(M_READ | M_MDRIN, OP_NOP, 1'b1, 1'b0, stp, 1'b0);
            push(M_READ | M_MDRIN, OP_NOP, 1'b1, 1'b1, stp, 1'b0);
        end
        push(M_MDROUT | M_IRIN, OP_NOP, 1'b1, rbit(), stp, 1'b0);
        if (is_alu || is_md) begin
            res = alu_model(opc, ref_regs[rb], ref_regs[rc]);
            push(M_GRB | M_ROUT | M_YIN, OP_NOP, 1'b1, rbit(), stp, 1'b0);
            push(M_GRC | M_ROUT | M_ZIN, opc, 1'b1, rbit(), stp, 1'b0);
            if (is_alu) begin
                push(M_ZLOWOUT | M_GRA | M_RIN, OP_NOP, 1'b1, rbit(), stp, abort);
                ref_regs[ra] = res[31:0];
            end else begin
                push(M_ZLOWOUT | M_LOIN, OP_NOP, 1'b1, rbit(), stp, abort);
                ref_lo = res[31:0];
                if (!abort) begin
                    push(M_ZHIGHOUT | M_HIIN, OP_NOP, 1'b1, rbit(), stp, 1'b0);
                    ref_hi = res[63:32];
                end
            end
        end else begin
            push(21'h0, OP_NOP, 1'b1, rbit(), stp, 1'b0);
        end
        if (abort) push_idle();
    endtask

    task automatic rand_instr(input logic stp);
        logic [4:0] opc;
        int ra, rb, rc;
        case ($urandom_range(0, 13))
            0:       opc = OP_ADD;
            1:       opc = OP_SUB;
            2:       opc = OP_AND;
            3:       opc = OP_OR;
            4:       opc = OP_SHR;
            5:       opc = OP_SHL;
            6:       opc = OP_ROR;
            7:       opc = OP_ROL;
            8:       opc = OP_MUL;
            9:       opc = OP_DIV;
            10:      opc = OP_NOP;
            11:      opc = 5'b00000;
            12:      opc = 5'b11111;
            default: opc = 5'b10110;
        endcase
        ra = int'($urandom_range(0, 15));
        rb = int'($urandom_range(0, 15));
        rc = int'($urandom_range(0, 15));
        if (opc == OP_DIV && ref_regs[rc] == 32'h0) opc = OP_MUL;
        add_instr(opc, ra, rb, rc, int'($urandom_range(0, 3)), stp, 1'b0);
    endtask

    task automatic run_queue();
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            clear     = e.clr;
            stop      = e.stp;
            mem_ready = e.mrdy;
            check($sformatf("cyc%0d", cyc), 64'({dut_strb, alu_op, run}),
                  64'({e.strb, e.op, e.rn}));
            cyc++;
            @(negedge Clock);
        end
    endtask

    initial begin
        clear = 1'b1; stop = 1'b0; mem_ready = 1'b0; dp_load = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 16; i++) init_regs[i] = $urandom;
        init_regs[0] = 32'h0;
        init_regs[2] = 32'h12;
        init_regs[3] = 32'h14;
        for (int i = 0; i < 16; i++) ref_regs[i] = init_regs[i];
        ref_hi = 32'h0;
        ref_lo = 32'h0;

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        dp_load = 1'b0;
        check("reset", 64'({dut_strb, alu_op, run}), 64'({21'h0, OP_NOP, 1'b0}));

        // Directed: ADD with wait states, MUL, undefined opcode, ADD cleared in T5.
        push_idle();
        add_instr(OP_ADD, 1, 2, 3, 3, 1'b0, 1'b0);
        add_instr(OP_MUL, 5, 2, 3, 0, 1'b0, 1'b0);
        add_instr(5'b11111, 7, 8, 9, 1, 1'b0, 1'b0);
        // R0 is zero, so the write-back coinciding with the clear edge leaves R1 intact.
        add_instr(OP_ADD, 1, 1, 0, 0, 1'b0, 1'b1);
        run_queue();
        check("r1_add", 64'(regs[1]), 64'h26);
        check("lo_mul", 64'(lo), 64'h168);
        check("hi_mul", 64'(hi), 64'h0);
        check("r5_no_rin", 64'(regs[5]), 64'(init_regs[5]));
        check("r7_undef", 64'(regs[7]), 64'(init_regs[7]));
        check("pc_inc", 64'(pc), 64'd4);

        for (int i = 0; i < 30; i++) rand_instr(1'b0);
        for (int i = 0; i < 2; i++) begin
            rand_instr(1'b1);
            push_halt(10, 1'b1);
        end
        for (int i = 0; i < 8; i++) rand_instr(1'b0);
        add_instr(OP_HALT, 0, 0, 0, 2, 1'b1, 1'b0);
        push_halt(10, 1'b0);
        run_queue();

        for (int i = 0; i < 16; i++)
            check($sformatf("r%0d", i), 64'(regs[i]), 64'(ref_regs[i]));
        check("hi_final", 64'(hi), 64'(ref_hi));
        check("lo_final", 64'(lo), 64'(ref_lo));
        check("pc_final", 64'(pc), 64'(ref_pc));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
